// File: rtl/lsu_mem_stage32.sv
// lsu_mem_stage32: load/store sequencer between execute and data_memory32.
// Accepts one request at a time, rejects illegal, misaligned or out-of-range accesses
// without touching memory, issues legal accesses for exactly one cycle, and extends
// loaded data locally. It also keeps saturating counts of completed accesses.
module lsu_mem_stage32 #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [2:0]       req_mode,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_mode,
  input  logic [31:0]      mem_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_error,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       mode_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             accept;
  logic             rsp_done;
  logic             in_access;
  logic             req_err;
  logic [1:0]       size_m1;
  logic [32:0]      last_byte;
  logic [31:0]      load_ext;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept    = (state_q == IDLE) && req_valid;
  assign rsp_done  = (state_q == RESP) && rsp_ready;
  assign in_access = (state_q == ACCESS);

  // Request legality: encoding, natural alignment and range of the last byte touched
  always_comb begin
    unique case (req_mode[1:0])
      2'b00:   size_m1 = 2'd0;
      2'b01:   size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    last_byte = {1'b0, req_addr} + {31'd0, size_m1};
    req_err   = 1'b0;
    if (req_mode == 3'b011 || req_mode == 3'b110 || req_mode == 3'b111)
      req_err = 1'b1;
    if (req_mode[1:0] == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_mode[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if (last_byte >= 33'(MEM_BYTES))
      req_err = 1'b1;
  end

  // Memory always returns zero-extended data; apply the requested extension here
  always_comb begin
    unique case (mode_q)
      3'b000:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  load_ext = {24'd0, mem_rdata[7:0]};
      3'b101:  load_ext = {16'd0, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = req_err ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture the request on accept and the extended load data at the end of ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      mode_q  <= req_mode;
      err_q   <= req_err;
      rdata_q <= '0;
    end else if (in_access && !we_q) begin
      rdata_q <= load_ext;
    end
  end

  // Counter next values: bump the matching counter on the response handshake
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (rsp_done) begin
      if (err_q)     err_cnt_d   = sat_inc(err_cnt_q);
      else if (we_q) store_cnt_d = sat_inc(store_cnt_q);
      else           load_cnt_d  = sat_inc(load_cnt_q);
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Memory port is driven only during ACCESS; decoded from state so rst drops it at once
  assign mem_we    = in_access && we_q;
  assign mem_addr  = in_access ? addr_q  : '0;
  assign mem_wdata = in_access ? wdata_q : '0;
  assign mem_mode  = in_access ? {1'b1, mode_q[1:0]} : '0;

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_error = rsp_valid && err_q;

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
